// File: rtl/accelerator_fnn_layer_scheduler.sv
// Sequences one feed-forward layer over a shared external MAC unit:
// walks (j,i), issues one MAC op per pair with a START/READY handshake, emits each h[j].
module accelerator_fnn_layer_scheduler #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic                    OP_READY,
  input  logic [DATA_SIZE-1:0]    OP_DATA_IN,
  output logic                    OP_START,
  output logic                    OP_FIRST,
  output logic [CONTROL_SIZE-1:0] INDEX_J_OUT,
  output logic [CONTROL_SIZE-1:0] INDEX_I_OUT,
  output logic [DATA_SIZE-1:0]    H_OUT,
  output logic                    H_OUT_ENABLE,
  output logic                    READY,
  output logic                    ERROR
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CONTROL_SIZE-1:0] One = CONTROL_SIZE'(1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StEmit,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] j_q, j_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d;
  logic [CONTROL_SIZE-1:0] size_j_q, size_j_d;
  logic [CONTROL_SIZE-1:0] size_i_q, size_i_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]    h_q, h_d;
  logic                    op_start_q, op_start_d;
  logic                    op_first_q, op_first_d;
  logic                    h_en_q, h_en_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;

  logic last_i;
  logic last_j;

  assign last_i = (i_q == size_i_q - One);
  assign last_j = (j_q == size_j_q - One);

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    i_d        = i_q;
    size_j_d   = size_j_q;
    size_i_d   = size_i_q;
    cnt_d      = cnt_q;
    h_d        = h_q;
    op_start_d = 1'b0;
    op_first_d = 1'b0;
    h_en_d     = 1'b0;
    ready_d    = 1'b0;
    error_d    = error_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          size_j_d = SIZE_J_IN;
          size_i_d = SIZE_I_IN;
          error_d  = 1'b0;
          j_d      = '0;
          i_d      = '0;
          if ((SIZE_J_IN == '0) || (SIZE_I_IN == '0)) begin
            state_d = StDone;
          end else begin
            state_d    = StIssue;
            op_start_d = 1'b1;
            op_first_d = 1'b1;
          end
        end
      end

      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end

      StWait: begin
        if (OP_READY) begin
          if (last_i) begin
            h_d     = OP_DATA_IN;
            h_en_d  = 1'b1;
            state_d = StEmit;
          end else begin
            i_d        = i_q + One;
            op_start_d = 1'b1;
            state_d    = StIssue;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
          // The MAC never answered: abort the layer and flag it until the next START.
          if (cnt_q == CntLast) begin
            error_d = 1'b1;
            state_d = StDone;
          end
        end
      end

      StEmit: begin
        if (last_j) begin
          state_d = StDone;
        end else begin
          j_d        = j_q + One;
          i_d        = '0;
          op_start_d = 1'b1;
          op_first_d = 1'b1;
          state_d    = StIssue;
        end
      end

      StDone: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      j_q        <= '0;
      i_q        <= '0;
      size_j_q   <= '0;
      size_i_q   <= '0;
      cnt_q      <= '0;
      h_q        <= '0;
      op_start_q <= 1'b0;
      op_first_q <= 1'b0;
      h_en_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      i_q        <= i_d;
      size_j_q   <= size_j_d;
      size_i_q   <= size_i_d;
      cnt_q      <= cnt_d;
      h_q        <= h_d;
      op_start_q <= op_start_d;
      op_first_q <= op_first_d;
      h_en_q     <= h_en_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  assign OP_START     = op_start_q;
  assign OP_FIRST     = op_first_q;
  assign INDEX_J_OUT  = j_q;
  assign INDEX_I_OUT  = i_q;
  assign H_OUT        = h_q;
  assign H_OUT_ENABLE = h_en_q;
  assign READY        = ready_q;
  assign ERROR        = error_q;

endmodule

// File: tb/tb_accelerator_fnn_layer_scheduler.sv
// Directed bench for the FNN layer scheduler with a small MAC model returning off+10*j+i.
module tb_accelerator_fnn_layer_scheduler;

  localparam int unsigned DS = 64;
  localparam int unsigned CS = 4;
  localparam int unsigned TO = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CS-1:0] size_j;
  logic [CS-1:0] size_i;
  logic          op_ready;
  logic [DS-1:0] op_data;
  logic          op_start;
  logic          op_first;
  logic [CS-1:0] index_j;
  logic [CS-1:0] index_i;
  logic [DS-1:0] h_out;
  logic          h_en;
  logic          ready;
  logic          error;

  accelerator_fnn_layer_scheduler #(
    .DATA_SIZE   (DS),
    .CONTROL_SIZE(CS),
    .TIMEOUT     (TO)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .START       (start),
    .SIZE_J_IN   (size_j),
    .SIZE_I_IN   (size_i),
    .OP_READY    (op_ready),
    .OP_DATA_IN  (op_data),
    .OP_START    (op_start),
    .OP_FIRST    (op_first),
    .INDEX_J_OUT (index_j),
    .INDEX_I_OUT (index_i),
    .H_OUT       (h_out),
    .H_OUT_ENABLE(h_en),
    .READY       (ready),
    .ERROR       (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // MAC model state
  int mac_lat = 1;
  int mac_off = 0;
  bit mac_dead = 1'b0;
  int pend = 0;
  int pj = 0;
  int pi = 0;

  // Event log
  logic [CS-1:0] log_j[32];
  logic [CS-1:0] log_i[32];
  logic          log_f[32];
  logic [DS-1:0] log_h[8];
  int n_ops, n_h, n_ready, ready_cyc, first_op_cyc, start_cyc;
  logic err_at_ready;

  int e2_j[6] = '{0, 0, 0, 1, 1, 1};
  int e2_i[6] = '{0, 1, 2, 0, 1, 2};
  int e2_f[6] = '{1, 0, 0, 1, 0, 0};
  int e6_j[4] = '{0, 0, 1, 1};
  int e6_i[4] = '{0, 1, 0, 1};
  int e6_f[4] = '{1, 0, 1, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clear_log();
    n_ops = 0;
    n_h = 0;
    n_ready = 0;
    ready_cyc = -1;
    first_op_cyc = -1;
    err_at_ready = 1'b0;
  endtask

  // One clock: MAC reacts just after the edge, monitor samples at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    op_ready = 1'b0;
    op_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          op_ready = 1'b1;
          op_data  = 64'(mac_off + 10 * pj + pi);
        end
      end
      if (op_start && !mac_dead) begin
        pend = mac_lat;
        pj   = int'(index_j);
        pi   = int'(index_i);
      end
    end
    @(negedge clk);
    if (op_start) begin
      if (n_ops < 32) begin
        log_j[n_ops] = index_j;
        log_i[n_ops] = index_i;
        log_f[n_ops] = op_first;
      end
      if (n_ops == 0) first_op_cyc = cyc;
      n_ops++;
    end
    if (h_en) begin
      if (n_h < 8) log_h[n_h] = h_out;
      n_h++;
    end
    if (ready) begin
      n_ready++;
      ready_cyc = cyc;
      err_at_ready = error;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_start(input int j, input int i);
    size_j = CS'(j);
    size_i = CS'(i);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_op_start"}, op_start, 0);
    chk({pfx, "_op_first"}, op_first, 0);
    chk({pfx, "_index_j"}, index_j, 0);
    chk({pfx, "_index_i"}, index_i, 0);
    chk({pfx, "_h_out"}, h_out, 0);
    chk({pfx, "_h_en"}, h_en, 0);
    chk({pfx, "_ready"}, ready, 0);
    chk({pfx, "_error"}, error, 0);
  endtask

  initial begin
    bit found;
    rst = 1'b0;
    start = 1'b0;
    size_j = '0;
    size_i = '0;
    op_ready = 1'b0;
    op_data = '0;
    clear_log();

    // 1: reset, START held during reset is ignored
    #2 rst = 1'b1;
    start = 1'b1;
    size_j = 4'd1;
    size_i = 4'd1;
    run(3);
    chk_outputs_zero("t1_inrst");
    start = 1'b0;
    rst = 1'b0;
    run(5);
    chk_outputs_zero("t1_after");
    chk("t1_no_ops", 64'(n_ops), 0);
    chk("t1_no_ready", 64'(n_ready), 0);

    // 2: 2x3 layer, MAC latency 1
    clear_log();
    mac_lat = 1;
    mac_off = 0;
    do_start(2, 3);
    run(25);
    chk("t2_ops", 64'(n_ops), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t2_j%0d", k), log_j[k], 64'(e2_j[k]));
      chk($sformatf("t2_i%0d", k), log_i[k], 64'(e2_i[k]));
      chk($sformatf("t2_first%0d", k), log_f[k], 64'(e2_f[k]));
    end
    chk("t2_n_h", 64'(n_h), 2);
    chk("t2_h0", log_h[0], 2);
    chk("t2_h1", log_h[1], 12);
    chk("t2_n_ready", 64'(n_ready), 1);
    chk("t2_latency", 64'(ready_cyc - start_cyc), 16);
    chk("t2_err", err_at_ready, 0);

    // 4: MAC never answers, timeout after TO wait cycles
    clear_log();
    mac_dead = 1'b1;
    do_start(1, 1);
    run(15);
    chk("t4_ops", 64'(n_ops), 1);
    chk("t4_n_ready", 64'(n_ready), 1);
    chk("t4_err_at_ready", err_at_ready, 1);
    // TO wait cycles, one DONE cycle, then READY
    chk("t4_ready_cyc", 64'(ready_cyc - first_op_cyc), 64'(TO + 2));
    chk("t4_err_sticky", error, 1);
    chk("t4_no_h", 64'(n_h), 0);
    mac_dead = 1'b0;

    // 3: empty layer, also clears the sticky error
    clear_log();
    do_start(0, 5);
    chk("t3_err_cleared", error, 0);
    run(10);
    chk("t3_ops", 64'(n_ops), 0);
    chk("t3_n_ready", 64'(n_ready), 1);
    chk("t3_latency", 64'(ready_cyc - start_cyc), 2);
    chk("t3_err", err_at_ready, 0);

    // 5: 1x1 layer, MAC latency 3, START re-pulsed mid-layer
    clear_log();
    mac_lat = 3;
    mac_off = 100;
    do_start(1, 1);
    tick();
    size_j = 4'd3;
    size_i = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(30);
    chk("t5_ops", 64'(n_ops), 1);
    chk("t5_first", log_f[0], 1);
    chk("t5_n_h", 64'(n_h), 1);
    chk("t5_h", log_h[0], 100);
    chk("t5_n_ready", 64'(n_ready), 1);
    chk("t5_latency", 64'(ready_cyc - start_cyc), 7);

    // 6: reset during WAIT of (1,1) in a 2x2 layer
    clear_log();
    mac_lat = 3;
    mac_off = 0;
    do_start(2, 2);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (n_ops == 4 && log_j[3] == 1 && log_i[3] == 1) found = 1'b1;
      else tick();
    end
    chk("t6_reach_11", found, 1);
    tick();
    chk("t6_pre_h", h_out, 1);
    #1 rst = 1'b1;
    #1 chk_outputs_zero("t6_rst");
    run(3);
    rst = 1'b0;
    run(20);
    chk("t6_no_ready", 64'(n_ready), 0);
    chk("t6_one_h", 64'(n_h), 1);

    clear_log();
    mac_lat = 1;
    do_start(2, 2);
    run(25);
    chk("t6r_ops", 64'(n_ops), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6r_j%0d", k), log_j[k], 64'(e6_j[k]));
      chk($sformatf("t6r_i%0d", k), log_i[k], 64'(e6_i[k]));
      chk($sformatf("t6r_first%0d", k), log_f[k], 64'(e6_f[k]));
    end
    chk("t6r_h0", log_h[0], 1);
    chk("t6r_h1", log_h[1], 11);
    chk("t6r_n_ready", 64'(n_ready), 1);
    chk("t6r_latency", 64'(ready_cyc - start_cyc), 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
